vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA timing generator and pixel-fetch front end for the Sobel display path.
//  Generalises the fixed 640x480 controller with configurable timings, sync polarity and pixel width.
//  Adds a pixel-request handshake with REQ_LEAD cycles of lead, so a registered or RAM-backed picture source can be read ahead.
//  Sits between the picture buffer (pix_req/pix_x/pix_y out, pix_data in) and the VGA pins.
// PARAMETERS
//  H_SYNC    96   hsync pulse width, pixel clocks
//  H_BACK    48   h back porch incl. left border
//  H_VALID   640  active pixels per line
//  H_FRONT   16   h front porch incl. right border; H_TOTAL = sum of the four H_* parameters
//  V_SYNC    2    vsync pulse width, lines
//  V_BACK    33   v back porch incl. top border
//  V_VALID   480  active lines per frame
//  V_FRONT   10   v front porch incl. bottom border; V_TOTAL = sum of the four V_* parameters
//  SYNC_POL  1    1: hsync/vsync high during pulse; 0: low during pulse
//  RGB_W     8    pixel width (RGB332 at 8)
//  CNT_W     10   counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
//  REQ_LEAD  1    cycles from pix_req to pix_data valid (>=1)
// PORTS
//  vga_clk      in   1      pixel clock; sole clock
//  sys_rst_n    in   1      synchronous active-low reset
//  pix_data     in   RGB_W  pixel from source, valid REQ_LEAD cycles after its pix_req
//  test_en      in   1      colour-bar select (only with VGA_TEST_PATTERN_EN)
//  pix_req      out  1      request pixel (pix_x,pix_y)
//  pix_x        out  CNT_W  active-area column; all-ones when pix_req=0
//  pix_y        out  CNT_W  active-area row; all-ones when pix_req=0
//  frame_start  out  1      1-cycle pulse at counter (h=0,v=0), request stage
//  hsync        out  1      horizontal sync, polarity per SYNC_POL
//  vsync        out  1      vertical sync, polarity per SYNC_POL
//  de           out  1      active-video enable, aligned with rgb
//  rgb          out  RGB_W  pixel to DAC; 0 whenever de=0
// BEHAVIOUR
//  - Reset (sys_rst_n=0 at a vga_clk edge): cnt_h=cnt_v=0; pix_req=0, pix_x=pix_y=all-ones, frame_start=0.
//    Reset also clears de=0, rgb=0, hsync=vsync=~SYNC_POL (inactive) and the whole delay line.
//    Reset mid-frame aborts the frame; timing restarts at (0,0) on release.
//  - cnt_h counts 0..H_TOTAL-1 and wraps to 0. cnt_v increments when cnt_h wraps; it wraps 0 at V_TOTAL-1.
//  - Active window: H_SYNC+H_BACK <= cnt_h < H_SYNC+H_BACK+H_VALID, with the same rule for cnt_v.
//  - Request stage, registered from counters (1 cycle after the counter value):
//    pix_req = active window; pix_x = cnt_h-(H_SYNC+H_BACK); pix_y = cnt_v-(V_SYNC+V_BACK).
//  - Handshake: no stall. A pix_req at cycle k obliges the source to present pix_data at cycle k+REQ_LEAD.
//  - Output stage: de and rgb register at cycle k+REQ_LEAD+1; rgb <= de_next ? pix_data : 0.
//    Outside the active window rgb=0 irrespective of pix_data.
//  - hsync = SYNC_POL when cnt_h < H_SYNC; vsync = SYNC_POL when cnt_v < V_SYNC.
//    Both pass through the same REQ_LEAD+1 delay as de, so sync/de/rgb stay mutually VGA-correct.
//  - frame_start coincides with the request stage of (0,0), once per frame.
//  - Throughput: exactly one request per active pixel; H_VALID*V_VALID requests per frame.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: test_en port exists. With test_en=1, pix_data is ignored.
//    rgb during de shows 8 vertical bars, bar = pix_x/(H_VALID/8), colours (RGB332):
//    FF,FC,1F,1C,E3,E0,03,00. pix_req still toggles normally.
//    test_en is sampled at the output stage, so a change takes effect on the next pixel.
//  Undefined: no test_en port; rgb is always from pix_data.
// TESTING (cfg H 2/3/4/1 -> H_TOTAL=10; V 1/2/3/1 -> V_TOTAL=7; REQ_LEAD=2; SYNC_POL=1)
//  - Reset held 5 cycles -> all outputs at reset values. After release, first pix_req follows counter (5,3).
//    That pix_req has pix_x=0, pix_y=0; frame_start pulses each 70 cycles.
//  - Source returns pix_data=pix_x+16*pix_y with 2-cycle latency -> de high 3 cycles after each pix_req.
//    rgb = 00,01,02,03 on row 0; 12 de-cycles per frame; rgb=0 whenever de=0.
//  - Sync widths -> hsync high 2 of every 10 cycles; vsync high 10 consecutive cycles per 70.
//    Both lag counter timing by exactly the de delay.
//  - Drive pix_data=AA outside request windows -> rgb stays 00.
//  - Assert reset mid-row (pix_x=2) for 1 cycle -> next cycle: pix_req=0, de=0, rgb=0.
//    Next frame_start comes 1 cycle after the counter restarts at (0,0).
//  - VGA_TEST_PATTERN_EN, H_VALID=640, test_en=1 -> rgb=FF for pix_x 0..79, FC at 80, 00 at 639.
//    test_en=0 -> rgb follows pix_data.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing generator with a read-ahead pixel request port.
// Free-running h/v counters drive a registered request stage
// (pix_req/pix_x/pix_y/frame_start). Raw sync and active flags then travel
// through a REQ_LEAD-deep delay line, so the output stage
// (de/rgb/hsync/vsync) lines up with pix_data returned REQ_LEAD cycles
// after its request.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   When defined, a test_en input exists. With test_en=1, rgb shows eight
//   vertical colour bars instead of pix_data.
//
// Ports
//   vga_clk      pixel clock, the only clock
//   sys_rst_n    synchronous active-low reset
//   pix_data     pixel from the source, valid REQ_LEAD cycles after pix_req
//   test_en      colour-bar select (only with VGA_TEST_PATTERN_EN)
//   pix_req      request for pixel (pix_x, pix_y)
//   pix_x/pix_y  active-area coordinates, all-ones when no request
//   frame_start  one-cycle pulse at the request stage of counter (0,0)
//   hsync/vsync  sync outputs, active level set by SYNC_POL
//   de           active-video enable, aligned with rgb
//   rgb          pixel to the DAC, zero whenever de=0
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_VALID  = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_VALID  = 480,
    parameter int V_FRONT  = 10,
    parameter int SYNC_POL = 1,
    parameter int RGB_W    = 8,
    parameter int CNT_W    = 10,
    parameter int REQ_LEAD = 1
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic [RGB_W-1:0] pix_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_en,
`endif
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_SYNC + H_BACK + H_VALID);
    localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_SYNC + V_BACK + V_VALID);
    localparam logic [CNT_W-1:0] H_SYN_E = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYN_E = CNT_W'(V_SYNC);
    localparam logic             POL     = (SYNC_POL != 0);

    logic [CNT_W-1:0]    cnt_h;
    logic [CNT_W-1:0]    cnt_v;
    logic                h_act;
    logic                v_act;
    logic                win;
    logic                hs_req;
    logic                vs_req;
    logic [REQ_LEAD-1:0] dl_req;
    logic [REQ_LEAD-1:0] dl_hs;
    logic [REQ_LEAD-1:0] dl_vs;
    logic [RGB_W-1:0]    px_src;

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
        end else begin
            cnt_h <= cnt_h + 1'b1;
        end
    end

    assign h_act = (cnt_h >= H_ACT_S) && (cnt_h < H_ACT_E);
    assign v_act = (cnt_v >= V_ACT_S) && (cnt_v < V_ACT_E);
    assign win   = h_act && v_act;

    // Request stage: everything here is one cycle behind the counters.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            pix_req     <= 1'b0;
            pix_x       <= '1;
            pix_y       <= '1;
            frame_start <= 1'b0;
            hs_req      <= ~POL;
            vs_req      <= ~POL;
        end else begin
            pix_req     <= win;
            pix_x       <= win ? cnt_h - H_ACT_S : '1;
            pix_y       <= win ? cnt_v - V_ACT_S : '1;
            frame_start <= (cnt_h == '0) && (cnt_v == '0);
            hs_req      <= (cnt_h < H_SYN_E) ? POL : ~POL;
            vs_req      <= (cnt_v < V_SYN_E) ? POL : ~POL;
        end
    end

    // Tap [REQ_LEAD-1] is valid in the same cycle as the returned pix_data.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            dl_req <= '0;
            dl_hs  <= {REQ_LEAD{~POL}};
            dl_vs  <= {REQ_LEAD{~POL}};
        end else begin
            dl_req[0] <= pix_req;
            dl_hs[0]  <= hs_req;
            dl_vs[0]  <= vs_req;
            for (int i = 1; i < REQ_LEAD; i++) begin
                dl_req[i] <= dl_req[i-1];
                dl_hs[i]  <= dl_hs[i-1];
                dl_vs[i]  <= dl_vs[i-1];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int               BAR_W_I = (H_VALID / 8 > 0) ? H_VALID / 8 : 1;
    localparam logic [CNT_W-1:0] BAR_W   = CNT_W'(BAR_W_I);
    localparam logic [7:0]       BAR_COL [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C,
                                                 8'hE3, 8'hE0, 8'h03, 8'h00};

    logic [CNT_W-1:0] dl_x [REQ_LEAD];
    logic [CNT_W-1:0] bar_q;
    logic [2:0]       bar_idx;

    // Column travels with the request so the bar index matches the pixel slot.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < REQ_LEAD; i++) dl_x[i] <= '0;
        end else begin
            dl_x[0] <= pix_x;
            for (int i = 1; i < REQ_LEAD; i++) dl_x[i] <= dl_x[i-1];
        end
    end

    // Clamp keeps a ragged last column (H_VALID not a multiple of 8) on bar 7.
    always_comb begin
        bar_q   = dl_x[REQ_LEAD-1] / BAR_W;
        bar_idx = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];
    end

    assign px_src = test_en ? RGB_W'(BAR_COL[bar_idx]) : pix_data;
`else
    assign px_src = pix_data;
`endif

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            de    <= 1'b0;
            rgb   <= '0;
            hsync <= ~POL;
            vsync <= ~POL;
        end else begin
            de    <= dl_req[REQ_LEAD-1];
            rgb   <= dl_req[REQ_LEAD-1] ? px_src : '0;
            hsync <= dl_hs[REQ_LEAD-1];
            vsync <= dl_vs[REQ_LEAD-1];
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Small-timing bench (H 2/3/4/1, V 1/2/3/1, REQ_LEAD=2). The source model
// answers each observed request REQ_LEAD cycles later. Expected outputs come
// from a cycle-index model: after the m-th clock edge since reset release,
// the request outputs describe counter position m, and the display outputs
// describe position m-REQ_LEAD-1.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HS = 2;
    localparam int HB = 3;
`ifdef VGA_TEST_PATTERN_EN
    localparam int HV = 640;
`else
    localparam int HV = 4;
`endif
    localparam int HF = 1;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VV = 3;
    localparam int VF = 1;
    localparam int L  = 2;
    localparam int CW = 10;
    localparam int RW = 8;
    localparam bit POL = 1'b1;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FR = HT * VT;
    localparam int VW = 2 * CW + RW + 5;
    localparam logic [7:0] BAR_TAB [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C,
                                           8'hE3, 8'hE0, 8'h03, 8'h00};

    logic          vga_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [RW-1:0] pix_data = '0;
`ifdef VGA_TEST_PATTERN_EN
    logic          test_en = 1'b0;
`endif
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          frame_start;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [RW-1:0] rgb;

    int          n_chk = 0;
    int          n_pass = 0;
    int          m = -1;
    logic        te_drv = 1'b0;
    logic        te_used = 1'b0;
    logic [7:0]  salt = 8'h00;
    bit          junk_rand = 1'b0;
    logic [2*CW:0] hq [$];
    logic [VW-1:0] obs;
    logic [VW-1:0] exp_v;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .SYNC_POL(1), .RGB_W(RW), .CNT_W(CW), .REQ_LEAD(L)
    ) u_dut (
        .vga_clk(vga_clk),
        .sys_rst_n(sys_rst_n),
        .pix_data(pix_data),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .pix_req(pix_req),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .frame_start(frame_start),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .rgb(rgb)
    );

    function automatic logic [RW-1:0] src(int x, int y, logic [7:0] s);
        return RW'(x + 16 * y) ^ s;
    endfunction

    function automatic logic [RW-1:0] bar(int x);
        int bw;
        int idx;
        bw  = (HV / 8 > 0) ? HV / 8 : 1;
        idx = x / bw;
        if (idx > 7) idx = 7;
        return BAR_TAB[idx];
    endfunction

    function automatic bit active(int h, int v);
        return (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
    endfunction

    // Expected {pix_req,pix_x,pix_y,frame_start,hsync,vsync,de,rgb} after edge mm.
    function automatic logic [VW-1:0] model(int mm, logic te, logic [7:0] s);
        int h, v, ho, vo, co;
        logic rq, fs, hsv, vsv, d;
        logic [CW-1:0] x, y;
        logic [RW-1:0] c;
        rq = 1'b0; fs = 1'b0; d = 1'b0; c = '0; x = '1; y = '1;
        hsv = ~POL; vsv = ~POL;
        if (mm >= 0) begin
            h  = mm % HT;
            v  = (mm / HT) % VT;
            fs = (h == 0) && (v == 0);
            if (active(h, v)) begin
                rq = 1'b1;
                x  = CW'(h - HS - HB);
                y  = CW'(v - VS - VB);
            end
        end
        co = mm - L - 1;
        if (co >= 0) begin
            ho  = co % HT;
            vo  = (co / HT) % VT;
            hsv = (ho < HS) ? POL : ~POL;
            vsv = (vo < VS) ? POL : ~POL;
            if (active(ho, vo)) begin
                d = 1'b1;
                c = te ? bar(ho - HS - HB) : src(ho - HS - HB, vo - VS - VB, s);
            end
        end
        return {rq, x, y, fs, hsv, vsv, d, c};
    endfunction

    // One clock: sample after the edge, update the cycle index, play the source.
    task automatic step();
        logic r_now;
        logic t_now;
        logic [2*CW:0] ent;
        r_now = sys_rst_n;
        t_now = te_drv;
        @(posedge vga_clk);
        #1;
        m = r_now ? m + 1 : -1;
        te_used = t_now;
        obs = {pix_req, pix_x, pix_y, frame_start, hsync, vsync, de, rgb};
        exp_v = model(m, te_used, salt);
        hq.push_back({pix_req, pix_x, pix_y});
        pix_data = junk_rand ? RW'($urandom) : 8'hAA;
        if (hq.size() > L) begin
            ent = hq.pop_front();
            if (ent[2*CW])
                pix_data = src(int'(ent[2*CW-1:CW]), int'(ent[CW-1:0]), salt);
        end
`ifdef VGA_TEST_PATTERN_EN
        test_en = te_drv;
`endif
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if (obs !== exp_v) $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_timing();
        int first_req, fs_cnt, de_cnt, hs_cnt, vs_cnt, vs_run, vs_max, n0;
        logic [RW-1:0] row0 [4];
        first_req = -1; fs_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        vs_run = 0; vs_max = 0; n0 = 0;
        salt = 8'h00;
        junk_rand = 1'b0;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3 * FR; i++) begin
            step();
            n_chk++;
            if (obs !== exp_v) $display("FAIL timing m=%0d got=%h exp=%h", m, obs, exp_v);
            else n_pass++;
            if (pix_req && first_req < 0) first_req = m;
            if (m >= FR) begin
                fs_cnt += int'(frame_start);
                de_cnt += int'(de);
                hs_cnt += int'(hsync);
                vs_cnt += int'(vsync);
            end
            vs_run = vsync ? vs_run + 1 : 0;
            if (vs_run > vs_max) vs_max = vs_run;
            if (de && n0 < 4) begin
                row0[n0] = rgb;
                n0++;
            end
        end
        n_chk++;
        if (first_req != (VS + VB) * HT + HS + HB)
            $display("FAIL first_req got=%0d exp=%0d", first_req, (VS + VB) * HT + HS + HB);
        else n_pass++;
        n_chk++;
        if (fs_cnt != 2) $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        else n_pass++;
        n_chk++;
        if (de_cnt != 2 * HV * VV) $display("FAIL de_count got=%0d exp=%0d", de_cnt, 2 * HV * VV);
        else n_pass++;
        n_chk++;
        if (hs_cnt != 2 * VT * HS) $display("FAIL hsync_count got=%0d exp=%0d", hs_cnt, 2 * VT * HS);
        else n_pass++;
        n_chk++;
        if (vs_cnt != 2 * VS * HT) $display("FAIL vsync_count got=%0d exp=%0d", vs_cnt, 2 * VS * HT);
        else n_pass++;
        n_chk++;
        if (vs_max != VS * HT) $display("FAIL vsync_run got=%0d exp=%0d", vs_max, VS * HT);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (n0 != 4 || row0[i] !== RW'(i))
                $display("FAIL row0_rgb idx=%0d got=%h exp=%h", i, row0[i], RW'(i));
            else n_pass++;
        end
    endtask

    task automatic test_random_data();
        salt = 8'($urandom);
        junk_rand = 1'b1;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            n_chk++;
            if (obs !== exp_v) $display("FAIL random m=%0d got=%h exp=%h", m, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        int fs_m;
        found = 1'b0;
        fs_m = -99;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            n_chk++;
            if (obs !== exp_v) $display("FAIL pre_reset m=%0d got=%h exp=%h", m, obs, exp_v);
            else n_pass++;
            if (m >= 0 && (m % HT) == HS + HB + 2 && ((m / HT) % VT) == VS + VB) begin
                found = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!found) $display("FAIL mid_reset_search got=timeout exp=pix_x2");
        else n_pass++;
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        n_chk++;
        if ({pix_req, de, rgb} !== '0)
            $display("FAIL mid_reset_clear got=%h exp=0", {pix_req, de, rgb});
        else n_pass++;
        n_chk++;
        if (obs !== exp_v) $display("FAIL mid_reset_state got=%h exp=%h", obs, exp_v);
        else n_pass++;
        for (int i = 0; i < FR + L + 2; i++) begin
            step();
            n_chk++;
            if (obs !== exp_v) $display("FAIL post_reset m=%0d got=%h exp=%h", m, obs, exp_v);
            else n_pass++;
            if (frame_start && fs_m == -99) fs_m = m;
        end
        n_chk++;
        if (fs_m != 0) $display("FAIL restart_frame_start got=%0d exp=0", fs_m);
        else n_pass++;
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int co, xo;
        logic [7:0] lit;
        te_drv = 1'b1;
        for (int i = 0; i < FR + L + 2; i++) begin
            step();
            n_chk++;
            if (obs !== exp_v) $display("FAIL pattern m=%0d got=%h exp=%h", m, obs, exp_v);
            else n_pass++;
            co = m - L - 1;
            if (te_used && co >= 0 && active(co % HT, (co / HT) % VT)) begin
                xo = (co % HT) - HS - HB;
                lit = 8'h55;
                if (xo == 0 || xo == 79) lit = 8'hFF;
                else if (xo == 80) lit = 8'hFC;
                else if (xo == 639) lit = 8'h00;
                if (lit != 8'h55) begin
                    n_chk++;
                    if (rgb !== lit) $display("FAIL bar_colour x=%0d got=%h exp=%h", xo, rgb, lit);
                    else n_pass++;
                end
            end
        end
        te_drv = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            n_chk++;
            if (obs !== exp_v) $display("FAIL pattern_off m=%0d got=%h exp=%h", m, obs, exp_v);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
        test_random_data();
        test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
